// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit map and default widths.
// Decode and every stage register pull their widths and bit indices from here.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int CNT_W_DEF  = 32;
  localparam int CTRL_W     = 9;

  // Control-bundle layout.
  localparam int REGDST_BIT   = 0;
  localparam int ALUSRC_BIT   = 1;
  localparam int MEMREAD_BIT  = 2;
  localparam int MEMWRITE_BIT = 3;
  localparam int MEMTOREG_BIT = 4;
  localparam int REGWRITE_BIT = 5;
  localparam int BRANCH_BIT   = 6;
  localparam int ALUOP_LSB    = 7;
  localparam int ALUOP_MSB    = 8;

  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } id_ex_act_e;

endpackage

// File: rtl/id_ex_load_use_detect.sv
// Combinational load-use comparator between the instruction in EX and the one in ID.
module id_ex_load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              load_use_o
);

  logic rt_nonzero;
  logic rt_match;

  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign rt_nonzero = (ex_rt_i != '0);
  assign rt_match   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
  assign load_use_o = ex_valid_i & ex_memread_i & rt_nonzero & rt_match & id_valid_i;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush bubble, valid bit and load-use flag.
// Optional stall/flush event counters are compiled in with ID_EX_PERF_EN.
module id_ex_pipe_reg #(
  parameter int DATA_W      = pipe_pkg::DATA_W_DEF,
  parameter int REG_AW      = pipe_pkg::REG_AW_DEF,
  parameter int CTRL_W      = pipe_pkg::CTRL_W,
  parameter int NUM_RD      = pipe_pkg::NUM_RD_DEF,
  parameter int MEMREAD_BIT = pipe_pkg::MEMREAD_BIT
`ifdef ID_EX_PERF_EN
  , parameter int CNT_W     = pipe_pkg::CNT_W_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic [DATA_W-1:0]        pc_next_in,
  input  logic [NUM_RD*DATA_W-1:0] rd_data_in,
  input  logic [DATA_W-1:0]        imm_in,
  input  logic [REG_AW-1:0]        rs_in,
  input  logic [REG_AW-1:0]        rt_in,
  input  logic [REG_AW-1:0]        rd_in,
  output logic                     valid_out,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic [DATA_W-1:0]        pc_next_out,
  output logic [DATA_W-1:0]        imm_out,
  output logic [NUM_RD*DATA_W-1:0] rd_data_out,
  output logic [REG_AW-1:0]        rs_out,
  output logic [REG_AW-1:0]        rt_out,
  output logic [REG_AW-1:0]        rd_out,
  output logic                     load_use_o
`ifdef ID_EX_PERF_EN
  , output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o
`endif
);

  pipe_pkg::id_ex_act_e act;

  logic                     valid_q,   valid_d;
  logic [CTRL_W-1:0]        ctrl_q,    ctrl_d;
  logic [DATA_W-1:0]        pc_next_q, pc_next_d;
  logic [DATA_W-1:0]        imm_q,     imm_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [REG_AW-1:0]        rs_q,      rs_d;
  logic [REG_AW-1:0]        rt_q,      rt_d;
  logic [REG_AW-1:0]        rd_q,      rd_d;

  // Flush outranks stall so a squashed instruction cannot be held in EX.
  always_comb begin
    if (flush)      act = pipe_pkg::ACT_FLUSH;
    else if (stall) act = pipe_pkg::ACT_STALL;
    else            act = pipe_pkg::ACT_LOAD;
  end

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    pc_next_d = pc_next_q;
    imm_d     = imm_q;
    rd_data_d = rd_data_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    case (act)
      pipe_pkg::ACT_LOAD: begin
        valid_d   = in_valid;
        ctrl_d    = in_valid ? ctrl_in : '0;
        pc_next_d = pc_next_in;
        imm_d     = imm_in;
        rd_data_d = rd_data_in;
        rs_d      = rs_in;
        rt_d      = rt_in;
        rd_d      = rd_in;
      end
      // Data fields keep stale values; the zeroed bundle makes them harmless.
      pipe_pkg::ACT_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc_next_q <= '0;
      imm_q     <= '0;
      rd_data_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      pc_next_q <= pc_next_d;
      imm_q     <= imm_d;
      rd_data_q <= rd_data_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  assign valid_out   = valid_q;
  assign ctrl_out    = ctrl_q;
  assign pc_next_out = pc_next_q;
  assign imm_out     = imm_q;
  assign rd_data_out = rd_data_q;
  assign rs_out      = rs_q;
  assign rt_out      = rt_q;
  assign rd_out      = rd_q;

  id_ex_load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q[MEMREAD_BIT]),
    .ex_rt_i      (rt_q),
    .id_valid_i   (in_valid),
    .id_rs_i      (rs_in),
    .id_rt_i      (rt_in),
    .load_use_o   (load_use_o)
  );

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (act == pipe_pkg::ACT_STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (act == pipe_pkg::ACT_FLUSH && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg against a behavioural pipeline-register model.
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 9;
  localparam int NUM_RD = 2;
  localparam int MRB    = 2;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk, reset, in_valid, stall, flush;
  logic [CTRL_W-1:0]        ctrl_in;
  logic [DATA_W-1:0]        pc_next_in, imm_in;
  logic [NUM_RD*DATA_W-1:0] rd_data_in;
  logic [REG_AW-1:0]        rs_in, rt_in, rd_in;
  logic                     valid_out, load_use_o;
  logic [CTRL_W-1:0]        ctrl_out;
  logic [DATA_W-1:0]        pc_next_out, imm_out;
  logic [NUM_RD*DATA_W-1:0] rd_data_out;
  logic [REG_AW-1:0]        rs_out, rt_out, rd_out;
`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0]         stall_cnt_o, flush_cnt_o;
`endif

  id_ex_pipe_reg #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .NUM_RD(NUM_RD), .MEMREAD_BIT(MRB)
`ifdef ID_EX_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ctrl_in(ctrl_in), .pc_next_in(pc_next_in), .rd_data_in(rd_data_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .valid_out(valid_out), .ctrl_out(ctrl_out), .pc_next_out(pc_next_out), .imm_out(imm_out),
    .rd_data_out(rd_data_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .load_use_o(load_use_o)
`ifdef ID_EX_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what EX should hold according to the priority rules.
  logic                     m_valid;
  logic [CTRL_W-1:0]        m_ctrl;
  logic [DATA_W-1:0]        m_pc, m_imm;
  logic [NUM_RD*DATA_W-1:0] m_rdd;
  logic [REG_AW-1:0]        m_rs, m_rt, m_rd;
  int                       m_scnt, m_fcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_imm = '0; m_rdd = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_scnt = 0; m_fcnt = 0;
  endfunction

  function automatic logic model_load_use();
    return m_valid && m_ctrl[MRB] && (m_rt != 0) && ((m_rt == rs_in) || (m_rt == rt_in)) && in_valid;
  endfunction

  task automatic rand_data();
    ctrl_in    = CTRL_W'($urandom);
    pc_next_in = $urandom;
    imm_in     = $urandom;
    rd_data_in = {$urandom, $urandom};
    rs_in      = REG_AW'($urandom);
    rt_in      = REG_AW'($urandom);
    rd_in      = REG_AW'($urandom);
  endtask

  // One clock edge; model updates with the inputs present at that edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else if (flush) begin
      m_valid = 1'b0; m_ctrl = '0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else if (stall) begin
      if (m_scnt < CNT_MAX) m_scnt++;
    end else begin
      m_valid = in_valid;
      m_ctrl  = in_valid ? ctrl_in : '0;
      m_pc = pc_next_in; m_imm = imm_in; m_rdd = rd_data_in;
      m_rs = rs_in; m_rt = rt_in; m_rd = rd_in;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_data(); cycle(); end
    stall = 1'b1; flush = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({valid_out, ctrl_out, pc_next_out, imm_out, rd_data_out, rs_out, rt_out, rd_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b ctrl=%h pc=%h imm=%h rd=%h rs=%h rt=%h rdo=%h required all zero",
               valid_out, ctrl_out, pc_next_out, imm_out, rd_data_out, rs_out, rt_out, rd_out);
    end
    rand_data(); stall = 1'b0; flush = 1'b0;
    cycle();
    n_checks++;
    if (valid_out !== 1'b0 || ctrl_out !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%b ctrl=%h required 0/000", valid_out, ctrl_out);
    end
`ifdef ID_EX_PERF_EN
    n_checks++;
    if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: stall_cnt=%0d flush_cnt=%0d required 0/0", stall_cnt_o, flush_cnt_o);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; ctrl_in = 9'h1A5;
    cycle();
    n_checks++;
    if (ctrl_out !== 9'h1A5 || valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_load: ctrl=%h valid=%b required 1a5/1", ctrl_out, valid_out);
    end
  endtask

  task automatic test_stall();
    rand_data(); in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    pc_next_in = 32'h0000_0104;
    cycle();
    for (int i = 0; i < 3; i++) begin
      rand_data(); in_valid = $urandom_range(0, 1); stall = 1'b1;
      cycle();
      n_checks++;
      if (pc_next_out !== 32'h0000_0104 || valid_out !== 1'b1 || ctrl_out !== m_ctrl) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h valid=%b ctrl=%h required 00000104/1/%h",
                 i, pc_next_out, valid_out, ctrl_out, m_ctrl);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_flush_stall();
    logic [NUM_RD*DATA_W-1:0] held;
    rand_data(); in_valid = 1'b1; ctrl_in = 9'h1FF; stall = 1'b0; flush = 1'b0;
    cycle();
    held = rd_data_out;
    for (int i = 0; i < 2; i++) begin
      rand_data(); in_valid = 1'b1; stall = 1'b1; flush = 1'b1;
      cycle();
      n_checks++;
      if (valid_out !== 1'b0 || ctrl_out !== '0 || rd_data_out !== held || rd_data_out !== m_rdd) begin
        n_fail++;
        $display("FAIL flush_bubble[%0d]: valid=%b ctrl=%h rd=%h required 0/000/%h",
                 i, valid_out, ctrl_out, rd_data_out, m_rdd);
      end
    end
    rand_data(); flush = 1'b0; stall = 1'b1;
    cycle();
    n_checks++;
    if (valid_out !== 1'b0 || ctrl_out !== '0) begin
      n_fail++;
      $display("FAIL flush_then_stall: valid=%b ctrl=%h required 0/000", valid_out, ctrl_out);
    end
    stall = 1'b0;
  endtask

  task automatic test_invalid();
    rand_data(); in_valid = 1'b0; ctrl_in = 9'h1FF; stall = 1'b0; flush = 1'b0;
    cycle();
    n_checks++;
    if (ctrl_out !== '0 || valid_out !== 1'b0 || rd_out !== m_rd) begin
      n_fail++;
      $display("FAIL invalid_in: ctrl=%h valid=%b rd=%h required 000/0/%h", ctrl_out, valid_out, rd_out, m_rd);
    end
  endtask

  task automatic load_lw(input logic [REG_AW-1:0] rt);
    rand_data(); in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    ctrl_in = 9'h004; rt_in = rt;
    cycle();
  endtask

  task automatic test_load_use();
    load_lw(5'd5);
    rs_in = 5'd5; rt_in = 5'd9; in_valid = 1'b1;
    #1;
    n_checks++;
    if (load_use_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_rs_hit: got %b required 1", load_use_o);
    end
    stall = 1'b1; flush = 1'b1;
    #1;
    n_checks++;
    if (load_use_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_ctrl_indep: got %b required 1", load_use_o);
    end
    stall = 1'b0; flush = 1'b0;
    rs_in = 5'd3; rt_in = 5'd5;
    #1;
    n_checks++;
    if (load_use_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_rt_hit: got %b required 1", load_use_o);
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (load_use_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_id_invalid: got %b required 0", load_use_o);
    end
    load_lw(5'd0);
    rs_in = 5'd0; rt_in = 5'd0; in_valid = 1'b1;
    #1;
    n_checks++;
    if (load_use_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_r0: got %b required 0", load_use_o);
    end
    load_lw(5'd5);
    rs_in = 5'd6; rt_in = 5'd7; in_valid = 1'b1;
    #1;
    n_checks++;
    if (load_use_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_nomatch: got %b required 0", load_use_o);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      rand_data();
      in_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) ctrl_in[MRB] = 1'b1;
      if ($urandom_range(0, 3) == 0) rs_in = m_rt;
      cycle();
      n_checks++;
      if ({valid_out, ctrl_out, pc_next_out, imm_out, rd_data_out, rs_out, rt_out, rd_out} !==
          {m_valid, m_ctrl, m_pc, m_imm, m_rdd, m_rs, m_rt, m_rd}) begin
        n_fail++; errs++;
        if (errs < 5)
          $display("FAIL random_regs[%0d]: valid=%b ctrl=%h pc=%h rt=%h required %b/%h/%h/%h",
                   i, valid_out, ctrl_out, pc_next_out, rt_out, m_valid, m_ctrl, m_pc, m_rt);
      end
      rs_in = ($urandom_range(0, 1) != 0) ? m_rt : REG_AW'($urandom);
      rt_in = REG_AW'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (load_use_o !== model_load_use()) begin
        n_fail++; errs++;
        if (errs < 5)
          $display("FAIL random_load_use[%0d]: got %b required %b", i, load_use_o, model_load_use());
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    stall = 1'b0; flush = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rand_data(); stall = 1'b1;
      cycle();
    end
    n_checks++;
    if (stall_cnt_o !== CNT_W'(m_scnt) || stall_cnt_o !== 4'hF) begin
      n_fail++;
      $display("FAIL perf_stall_sat: got %0d required 15", stall_cnt_o);
    end
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      flush = 1'b1; stall = i[0];
      cycle();
    end
    flush = 1'b0; stall = 1'b0;
    cycle();
    n_checks++;
    if (flush_cnt_o !== CNT_W'(m_fcnt) || flush_cnt_o !== 4'd2 || stall_cnt_o !== 4'hF) begin
      n_fail++;
      $display("FAIL perf_flush_cnt: flush=%0d stall=%0d required 2/15", flush_cnt_o, stall_cnt_o);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    rand_data();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_stall();
    test_flush_stall();
    test_invalid();
    test_load_use();
    test_random();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register with stall (hold), flush (bubble insertion), a valid bit and load-use hazard detection. It replaces the fixed-field ID/EX buffer between decode and execute. Control signals travel as one packed bundle; operand channels are configurable. An optional stall/flush event counter is compiled in with a macro.

## Interface
Parameters:
- DATA_W, 32, width of PC, operand and immediate words
- REG_AW, 5, register-address width
- CTRL_W, 9, packed control-bundle width
- NUM_RD, 2, number of register-read operand channels (≥1)
- MEMREAD_BIT, 2, index of MemRead inside the control bundle
- CNT_W, 32, event-counter width (used only with ID_EX_PERF_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ID stage holds a real instruction
- stall  in  1  hold all registers this cycle
- flush  in  1  insert bubble this cycle
- ctrl_in  in  CTRL_W  packed control bundle from decode
- pc_next_in  in  DATA_W  PC+4 of the ID instruction
- rd_data_in  in  NUM_RD*DATA_W  operands; channel k at [k*DATA_W +: DATA_W]
- imm_in  in  DATA_W  sign-extended immediate
- rs_in, rt_in, rd_in  in  REG_AW each  register specifiers
- valid_out  out  1  EX holds a real instruction
- ctrl_out  out  CTRL_W  registered control bundle
- pc_next_out, imm_out  out  DATA_W each
- rd_data_out  out  NUM_RD*DATA_W
- rs_out, rt_out, rd_out  out  REG_AW each
- load_use_o  out  1  combinational load-use hazard flag
- stall_cnt_o, flush_cnt_o  out  CNT_W each  present only with ID_EX_PERF_EN

## Operation
- Per-cycle priority: reset > flush > stall > load.
- Load (flush=0, stall=0): all data fields capture inputs; valid_out <= in_valid; ctrl_out <= in_valid ? ctrl_in : 0.
- Stall (flush=0, stall=1): every register, including valid_out, holds.
- Flush (flush=1, stall ignored): valid_out <= 0, ctrl_out <= 0; data fields hold their previous values (don't-care downstream).
- A bubble is therefore defined as valid_out=0 with ctrl_out all-zero; no write or memory side effects reach later stages.
- load_use_o = valid_out & ctrl_out[MEMREAD_BIT] & (rt_out != 0) & (rt_out == rs_in | rt_out == rt_in), gated with in_valid. This is combinational from registered state and current ID inputs. The parent stalls IF/ID and drives flush here on the next edge; this block does not self-flush.
- Reset (reset=0, asynchronous assert, synchronous-to-clk deassert at the parent): every output register is 0, so valid_out=0, ctrl_out=0, all data/specifier outputs 0, and counters 0.

## Timing
- Latency 1 cycle: inputs sampled at edge n appear on outputs after edge n.
- load_use_o has zero latency and depends only on outputs and the rs_in/rt_in/in_valid inputs. No path exists from stall or flush to load_use_o.
- Reset asserted mid-stall or mid-flush clears immediately and ignores the other controls.
- Back-to-back flushes produce consecutive bubbles. A flush followed by a stall holds the bubble.

## Configuration
- ID_EX_PERF_EN defined: stall_cnt_o increments on every edge with stall=1 & flush=0; flush_cnt_o increments on every edge with flush=1. Both saturate at all-ones and clear on reset.
- ID_EX_PERF_EN undefined: counter ports and logic are absent, and all other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - control-bit index constants (REGWRITE_BIT, MEMTOREG_BIT, MEMREAD_BIT, MEMWRITE_BIT, REGDST_BIT, ALUSRC_BIT, ALUOP_LSB/MSB, BRANCH_BIT)
  - CTRL_W and the default widths, so decode and all stage registers agree.
- One sub-module: id_ex_load_use_detect, the purely combinational hazard comparator, reused by later pipeline variants.

## Test plan
- Reset: drive random inputs, pull reset=0 mid-cycle -> all outputs 0 immediately. Release, load ctrl_in=9'h1A5, in_valid=1 -> ctrl_out=9'h1A5, valid_out=1 one edge later.
- Stall: load pc_next_in=32'h0000_0104, then stall=1 for 3 cycles with changing inputs -> pc_next_out stays 32'h0000_0104 and valid_out stays 1.
- Flush vs stall: flush=1 and stall=1 together -> valid_out=0, ctrl_out=0, rd_data_out unchanged.
- Invalid input: in_valid=0, ctrl_in=9'h1FF -> ctrl_out=0, valid_out=0.
- Load-use: EX holds lw with MemRead=1, rt_out=5; ID rs_in=5 -> load_use_o=1. Repeat with rt_out=0 -> load_use_o=0. Repeat with rs_in=6, rt_in=7 -> load_use_o=0.
- Perf (ID_EX_PERF_EN, CNT_W=4): 20 stall cycles -> stall_cnt_o saturates at 4'hF. 2 flushes -> flush_cnt_o=2.
